m_lsu: RTL

Load/store unit for the M stage of the pipelined CPU: the initiator that drives the data-memory port instead of writing it as a single-cycle array. It accepts the M-stage memory operation, formats stores (byte enables, lane replication), issues a req/ack bus transaction to the data memory, and aligns and extends load data. While the transaction is outstanding it stalls the pipeline.

---
 rtl/m_defs.sv | 46 ++++
 rtl/m_lsu_fmt.sv | 51 +++++
 rtl/m_lsu.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/m_defs.sv
// Shared encodings for the M-stage load/store unit: memory ops, FSM states, decode helpers.
package m_defs;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LW   = 4'd1,
        MEM_LH   = 4'd2,
        MEM_LHU  = 4'd3,
        MEM_LB   = 4'd4,
        MEM_LBU  = 4'd5,
        MEM_SW   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SB   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StDone = 2'd2
    } lsu_state_e;

    function automatic logic op_valid(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd8);
    endfunction

    function automatic logic op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd5);
    endfunction

    function automatic logic op_is_store(input logic [3:0] op);
        return (op >= 4'd6) && (op <= 4'd8);
    endfunction

    // Word ops need addr[1:0]==0, halfword ops need addr[0]==0, bytes never trap.
    function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
        logic mis;
        mis = 1'b0;
        case (op)
            MEM_LW, MEM_SW:          mis = (off != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: mis = off[0];
            default:                 mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/m_lsu_fmt.sv
// Combinational store formatter (byte enables, lane replication) and load lane extractor.
module m_lsu_fmt
    import m_defs::*;
(
    input  logic [3:0]  st_op_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_wd_i,
    output logic        st_we_o,
    output logic [3:0]  st_be_o,
    output logic [31:0] st_wdata_o,
    input  logic [3:0]  ld_op_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_rd_o
);

    logic [31:0] lane;

    always_comb begin
        st_we_o    = op_is_store(st_op_i);
        st_be_o    = 4'b1111;
        st_wdata_o = 32'h0;
        case (st_op_i)
            MEM_SW: st_wdata_o = st_wd_i;
            MEM_SH: begin
                st_be_o    = st_off_i[1] ? 4'b1100 : 4'b0011;
                st_wdata_o = {2{st_wd_i[15:0]}};
            end
            MEM_SB: begin
                st_be_o    = 4'b0001 << st_off_i;
                st_wdata_o = {4{st_wd_i[7:0]}};
            end
            default: ;
        endcase
    end

    assign lane = ld_rdata_i >> {ld_off_i, 3'b000};

    always_comb begin
        ld_rd_o = 32'h0;
        case (ld_op_i)
            MEM_LW:  ld_rd_o = ld_rdata_i;
            MEM_LH:  ld_rd_o = {{16{lane[15]}}, lane[15:0]};
            MEM_LHU: ld_rd_o = {16'h0, lane[15:0]};
            MEM_LB:  ld_rd_o = {{24{lane[7]}}, lane[7:0]};
            MEM_LBU: ld_rd_o = {24'h0, lane[7:0]};
            default: ld_rd_o = 32'h0;
        endcase
    end

endmodule

// File: rtl/m_lsu.sv
// M-stage load/store unit: req/ack bus initiator with pipeline stall.
// Optional bus-wait abort compiled in with LSU_TIMEOUT_EN.
module m_lsu
    import m_defs::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  memOp,
    input  logic [31:0] memDst,
    input  logic [31:0] memWd,
    output logic        stall,
    output logic [31:0] rd,
    output logic        memExc,
    output logic        busErr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    lsu_state_e  state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  op_q, op_d;
    logic [1:0]  off_q, off_d;

    logic        fmt_we;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] fmt_rd;
    logic        valid;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    m_lsu_fmt u_fmt (
        .st_op_i    (memOp),
        .st_off_i   (memDst[1:0]),
        .st_wd_i    (memWd),
        .st_we_o    (fmt_we),
        .st_be_o    (fmt_be),
        .st_wdata_o (fmt_wdata),
        .ld_op_i    (op_q),
        .ld_off_i   (off_q),
        .ld_rdata_i (rdata_q),
        .ld_rd_o    (fmt_rd)
    );

    assign valid  = op_valid(memOp);
    assign memExc = valid && op_misaligned(memOp, memDst[1:0]);
    assign stall  = valid && !memExc && (state_q != StDone);

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        op_d    = op_q;
        off_d   = off_q;
`ifdef LSU_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (valid && !memExc) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                    we_d    = fmt_we;
                    addr_d  = {memDst[31:2], 2'b00};
                    be_d    = fmt_be;
                    wdata_d = fmt_wdata;
                    rdata_d = 32'h0;
                    op_d    = memOp;
                    off_d   = memDst[1:0];
`ifdef LSU_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StReq: begin
                if (bus_ack) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    if (op_is_load(op_q)) begin
                        rdata_d = bus_rdata;
                    end
`ifdef LSU_TIMEOUT_EN
                end else if ((cnt_q + 1'b1) == CntW'(TIMEOUT)) begin
                    // Abort: finish with zero load data so rd reads 0 in DONE.
                    state_d = StDone;
                    req_d   = 1'b0;
                    rdata_d = 32'h0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            op_q    <= MEM_NONE;
            off_q   <= 2'b00;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            op_q    <= op_d;
            off_q   <= off_d;
`ifdef LSU_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign rd        = (state_q == StDone) ? fmt_rd : 32'h0;
    assign bus_req   = req_q;
    assign bus_we    = we_q;
    assign bus_addr  = addr_q;
    assign bus_be    = be_q;
    assign bus_wdata = wdata_q;
`ifdef LSU_TIMEOUT_EN
    assign busErr    = err_q;
`else
    assign busErr    = 1'b0;
`endif

endmodule
